// File: rtl/fx_channel_engine_if.sv
// Frame-in / frame-out sample bus of the multi-channel distortion engine.
// The engine sits on the slave side; the audio front end is the master.
interface fx_channel_engine_if #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 16,
   parameter int GAIN_W   = 8
);
   logic                       in_valid;
   logic                       in_ready;
   logic [CHANNELS*DATA_W-1:0] in_frame;
   logic [1:0]                 mode;
   logic [GAIN_W-1:0]          gain;
   logic                       out_valid;
   logic [CHANNELS*DATA_W-1:0] out_frame;
   logic                       fading;

   modport master (output in_valid, in_frame, mode, gain,
                   input  in_ready, out_valid, out_frame, fading);
   modport slave  (input  in_valid, in_frame, mode, gain,
                   output in_ready, out_valid, out_frame, fading);
endinterface

// File: rtl/fx_channel_engine.sv
// Time-multiplexed distortion engine: one channel per cycle through a
// gain -> shape -> blend pipeline, with a crossfade on every mode change.
module fx_channel_engine #(
   parameter int CHANNELS   = 2,
   parameter int DATA_W     = 16,
   parameter int GAIN_W     = 8,
   parameter int FADE_SHIFT = 6
) (
   input logic                CLOCK_50,
   input logic                reset_n,
   fx_channel_engine_if.slave bus
);
   localparam int CW = $clog2(CHANNELS + 2);
   localparam int PW = DATA_W + GAIN_W + 1;
   localparam int BW = DATA_W + FADE_SHIFT + 2;
   localparam logic signed [DATA_W-1:0] DMAX  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] DMIN  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [PW-1:0]     PMAX  = PW'(DMAX);
   localparam logic signed [PW-1:0]     PMIN  = PW'(DMIN);
   localparam logic signed [DATA_W:0]   TW    = {3'b000, 1'b1, {(DATA_W-3){1'b0}}};
   localparam logic signed [DATA_W:0]   TQ    = {5'b00000, 1'b1, {(DATA_W-5){1'b0}}};
   localparam logic [FADE_SHIFT:0]      KFULL = {1'b1, {FADE_SHIFT{1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                           state_q, state_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic [CHANNELS-1:0][DATA_W-1:0]  frame_q, frame_d, res_q, res_d, out_q, out_d;
   logic [GAIN_W-1:0]                gain_q, gain_d;
   logic [1:0]                       act_q, act_d, old_q, old_d;
   logic [FADE_SHIFT-1:0]            k_q, k_d;
   logic                             fading_q, fading_d, ready_q, ready_d;
   logic signed [DATA_W-1:0]         s1_q, s1_d, s2n_q, s2n_d, s2o_q, s2o_d;
   logic signed [DATA_W-1:0]         samp, blnd;
   logic signed [PW-1:0]             prod;
   logic signed [BW-1:0]             acc;
   logic                             accept;

   function automatic logic signed [DATA_W-1:0] shape(input logic [1:0] m,
                                                      input logic signed [DATA_W-1:0] x);
      logic signed [DATA_W:0] xw, ax, r;
      xw = DATA_W'(x) == x ? {x[DATA_W-1], x} : {x[DATA_W-1], x};
      ax = xw[DATA_W] ? -xw : xw;
      r  = xw;
      case (m)
         2'b01: if (ax > TW) r = xw[DATA_W] ? -(TW + ((ax - TW) >>> 2)) : (TW + ((ax - TW) >>> 2));
         2'b10: if (xw > TW) r = TW; else if (xw < -TW) r = -TW;
         2'b11: begin
            if (xw > TQ) r = TQ; else if (xw < -TQ) r = -TQ;
            r = r <<< 2;
         end
         default: r = xw;
      endcase
      return r[DATA_W-1:0];
   endfunction

   assign accept        = bus.in_valid && ready_q;
   assign bus.in_ready  = ready_q;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_frame = out_q;
   assign bus.fading    = fading_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      frame_d  = frame_q;
      gain_d   = gain_q;
      act_d    = act_q;
      old_d    = old_q;
      k_d      = k_q;
      fading_d = fading_q;
      out_d    = out_q;
      res_d    = res_q;
      samp     = '0;

      for (int c = 0; c < CHANNELS; c++)
         if (cnt_q == CW'(c)) samp = frame_q[c];
      prod = PW'(samp) * PW'($signed({1'b0, gain_q}));
      prod = prod >>> (GAIN_W - 4);
      if (prod > PMAX)      s1_d = DMAX;
      else if (prod < PMIN) s1_d = DMIN;
      else                  s1_d = prod[DATA_W-1:0];

      s2n_d = shape(act_q, s1_q);
      s2o_d = shape(old_q, s1_q);

      // k weights the outgoing mode; k=0 passes the active mode straight through
      acc  = BW'(s2o_q) * BW'($signed({1'b0, k_q}))
           + BW'(s2n_q) * BW'($signed({1'b0, KFULL - {1'b0, k_q}}));
      acc  = acc >>> FADE_SHIFT;
      blnd = acc[DATA_W-1:0];

      if (state_q == RUN)
         for (int c = 0; c < CHANNELS; c++)
            if (cnt_q == CW'(c + 2)) res_d[c] = blnd;

      unique case (state_q)
         IDLE: if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            frame_d = bus.in_frame;
            gain_d  = bus.gain;
            if (!fading_q && bus.mode != act_q) begin
               old_d    = act_q;
               act_d    = bus.mode;
               k_d      = '1;
               fading_d = 1'b1;
            end else if (fading_q) begin
               k_d = k_q - FADE_SHIFT'(1);
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(CHANNELS + 1)) begin
               state_d = DONE;
               out_d   = res_d;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (fading_q && k_q == '0) fading_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         frame_q  <= '0;
         res_q    <= '0;
         out_q    <= '0;
         gain_q   <= '0;
         act_q    <= 2'b00;
         old_q    <= 2'b00;
         k_q      <= '0;
         fading_q <= 1'b0;
         ready_q  <= 1'b0;
         s1_q     <= '0;
         s2n_q    <= '0;
         s2o_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         res_q    <= res_d;
         out_q    <= out_d;
         gain_q   <= gain_d;
         act_q    <= act_d;
         old_q    <= old_d;
         k_q      <= k_d;
         fading_q <= fading_d;
         ready_q  <= ready_d;
         s1_q     <= s1_d;
         s2n_q    <= s2n_d;
         s2o_q    <= s2o_d;
      end
   end
endmodule
